// File: rtl/dmem_lsu.sv
// dmem_lsu -- load/store initiator between the core memory stage and a
// byte-banked, single-port data RAM with one cycle of read latency.
//
// Takes one RV32 load/store per valid&ready handshake. It drives the RAM
// word address, byte-lane write mask, lane-shifted write data and read
// strobe. Load data comes back aligned and sign- or zero-extended.
//
// Optional feature macro: DMEM_LSU_MISALIGN_EN
//   defined   : accesses that cross a word boundary are split into two
//               consecutive RAM accesses (ACC0 then ACC1).
//   undefined : crossing accesses make no RAM access and respond with
//               resp_err_o=1.
//
// Ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   req_valid_i / req_ready_o       request handshake
//   req_we_i, req_addr_i,
//   req_funct3_i, req_wdata_i       store flag, byte address, RV32 funct3,
//                                   LSB-aligned store data
//   resp_valid_o                    one-cycle response pulse
//   resp_rdata_o, resp_err_o        extended load data and error flag
//   mem_addr_o                      word-aligned RAM byte address
//   mem_read_o, mem_write_o         RAM strobes (never both high)
//   mem_size_o, mem_din_o           byte-lane write mask, lane-shifted data
//   mem_dout_i                      RAM read data, valid one cycle after
//                                   mem_read_o
module dmem_lsu #(
  parameter int DMEM_ADDR_WIDTH = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_we_i,
  input  logic [31:0]                req_addr_i,
  input  logic [2:0]                 req_funct3_i,
  input  logic [31:0]                req_wdata_i,
  output logic                       resp_valid_o,
  output logic [31:0]                resp_rdata_o,
  output logic                       resp_err_o,
  output logic [DMEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic                       mem_read_o,
  output logic                       mem_write_o,
  output logic [3:0]                 mem_size_o,
  output logic [31:0]                mem_din_o,
  input  logic [31:0]                mem_dout_i
);

  localparam int W = DMEM_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t state, state_next;

  // Latched request
  logic         we_q;
  logic [W-1:0] addr_q;
  logic [2:0]   funct3_q;
  logic [31:0]  wdata_q;
  logic         err_q;

  // The upper request address bits are outside the RAM and are dropped.
  logic addr_hi_unused;
  assign addr_hi_unused = ^req_addr_i[31:W];

  // Decode of the incoming funct3. Loads allow 000/001/010/100/101.
  // Stores allow 000/001/010.
  logic illegal_in;
  always_comb begin
    illegal_in = 1'b0;
    if (req_we_i)
      illegal_in = req_funct3_i[2] | (req_funct3_i[1:0] == 2'b11);
    else
      illegal_in = (req_funct3_i[1:0] == 2'b11) | (req_funct3_i[2:1] == 2'b11);
  end

  // Geometry of the latched access
  logic [1:0] off;
  logic [2:0] nbytes;
  logic [3:0] mask_n;
  logic [2:0] span;
  logic       crossing;

  assign off = addr_q[1:0];

  always_comb begin
    nbytes = 3'd4;
    mask_n = 4'b1111;
    case (funct3_q[1:0])
      2'b00: begin nbytes = 3'd1; mask_n = 4'b0001; end
      2'b01: begin nbytes = 3'd2; mask_n = 4'b0011; end
      default: ;
    endcase
  end

  assign span     = {1'b0, off} + nbytes;
  assign crossing = (span > 3'd4);

  // Lane placement. The low four mask bits and the low data word go to the
  // first word. The bits that spill past lane 3 go to the second word.
  logic [3:0]  mask0;
  logic [31:0] din0;
  assign mask0 = 4'({4'b0000, mask_n} << off);
  assign din0  = wdata_q << {off, 3'b000};

`ifdef DMEM_LSU_MISALIGN_EN
  localparam int WW = W - 2;
  logic [31:0]   lo_q;
  logic [3:0]    mask1;
  logic [31:0]   din1;
  logic [WW-1:0] word_next;
  assign mask1     = 4'(({4'b0000, mask_n} << off) >> 4);
  assign din1      = 32'(({32'h0, wdata_q} << {off, 3'b000}) >> 32);
  assign word_next = addr_q[W-1:2] + WW'(1);
`endif

  // State and request registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      funct3_q <= 3'b000;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
`ifdef DMEM_LSU_MISALIGN_EN
      lo_q     <= 32'h0;
`endif
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid_i) begin
        we_q     <= req_we_i;
        addr_q   <= req_addr_i[W-1:0];
        funct3_q <= req_funct3_i;
        wdata_q  <= req_wdata_i;
        err_q    <= illegal_in;
      end
`ifdef DMEM_LSU_MISALIGN_EN
      // The first word of a split load arrives while the second is read.
      if (state == ACC1)
        lo_q <= mem_dout_i;
`endif
    end
  end

  // Next state and RAM-side outputs
  always_comb begin
    state_next   = state;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    mem_addr_o   = '0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_size_o   = 4'b0000;
    mem_din_o    = 32'h0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i)
          state_next = illegal_in ? RESP : ACC0;
      end
      ACC0: begin
        mem_addr_o = {addr_q[W-1:2], 2'b00};
`ifdef DMEM_LSU_MISALIGN_EN
        mem_read_o  = ~we_q;
        mem_write_o = we_q;
        if (we_q) begin
          mem_size_o = mask0;
          mem_din_o  = din0;
        end
        state_next = crossing ? ACC1 : RESP;
`else
        // An unsupported crossing access touches no RAM and reports an error.
        if (!crossing) begin
          mem_read_o  = ~we_q;
          mem_write_o = we_q;
          if (we_q) begin
            mem_size_o = mask0;
            mem_din_o  = din0;
          end
        end
        state_next = RESP;
`endif
      end
`ifdef DMEM_LSU_MISALIGN_EN
      ACC1: begin
        mem_addr_o  = {word_next, 2'b00};
        mem_read_o  = ~we_q;
        mem_write_o = we_q;
        if (we_q) begin
          mem_size_o = mask1;
          mem_din_o  = din1;
        end
        state_next = RESP;
      end
`endif
      RESP: begin
        resp_valid_o = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Load alignment and extension. The value is combinational from
  // mem_dout_i, which holds the last word read when in RESP.
  logic [31:0] ld_shift;
  logic [31:0] ld_data;

  always_comb begin
`ifdef DMEM_LSU_MISALIGN_EN
    if (crossing)
      ld_shift = 32'({mem_dout_i, lo_q} >> {off, 3'b000});
    else
      ld_shift = mem_dout_i >> {off, 3'b000};
`else
    ld_shift = mem_dout_i >> {off, 3'b000};
`endif
  end

  always_comb begin
    ld_data = ld_shift;
    case (funct3_q[1:0])
      2'b00: ld_data = funct3_q[2] ? {24'h0, ld_shift[7:0]}
                                   : {{24{ld_shift[7]}}, ld_shift[7:0]};
      2'b01: ld_data = funct3_q[2] ? {16'h0, ld_shift[15:0]}
                                   : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ;
    endcase
  end

  logic resp_err;
`ifdef DMEM_LSU_MISALIGN_EN
  assign resp_err = err_q;
`else
  assign resp_err = err_q | crossing;
`endif

  assign resp_err_o   = (state == RESP) & resp_err;
  assign resp_rdata_o = (state == RESP && !we_q && !resp_err) ? ld_data : 32'h0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Testbench for dmem_lsu (DMEM_ADDR_WIDTH=10). Directed requests push the
// expected RAM accesses and responses, with their expected cycle numbers,
// into two queues. A monitor on the falling edge pops an entry and compares
// it whenever the DUT strobes the RAM or pulses resp_valid_o.
module tb_dmem_lsu;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [31:0]   req_addr = 32'h0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [31:0]   req_wdata = 32'h0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic          mem_write;
  logic [3:0]    mem_size;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;

  always #5 clk = ~clk;

  dmem_lsu #(.DMEM_ADDR_WIDTH(AW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_funct3_i (req_funct3),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .mem_addr_o   (mem_addr),
    .mem_read_o   (mem_read),
    .mem_write_o  (mem_write),
    .mem_size_o   (mem_size),
    .mem_din_o    (mem_din),
    .mem_dout_i   (mem_dout)
  );

  // Byte-banked RAM, one-cycle read latency, cleared while in reset
  logic [31:0] ram [0:255];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
      mem_dout <= 32'h0;
    end else begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_size[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_din[8*b +: 8];
      mem_dout <= mem_read ? ram[mem_addr[9:2]] : 32'h0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit        we;
    bit [9:0]  addr;
    bit [3:0]  mask;
    bit [31:0] din;
    int        cyc;
  } mem_exp_t;

  typedef struct {
    bit [31:0] rdata;
    bit        err;
    int        cyc;
  } resp_exp_t;

  mem_exp_t  mq[$];
  resp_exp_t rq[$];
  mem_exp_t  me;
  resp_exp_t re;
  int n_cmp = 0;
  int n_bad = 0;
  int n_resp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_read && mem_write) begin
        n_cmp++; n_bad++;
        $display("FAIL strobe_excl: got read=1 write=1, required at most one strobe");
      end
      if (mem_read || mem_write) begin
        n_cmp++;
        if (mq.size() == 0) begin
          n_bad++;
          $display("FAIL mem_unexp: got we=%0d addr=%h mask=%b din=%h cyc=%0d, required no access",
                   mem_write, mem_addr, mem_size, mem_din, cyc);
        end else begin
          me = mq.pop_front();
          if (mem_write !== me.we || mem_addr !== me.addr || mem_size !== me.mask ||
              mem_din !== me.din || cyc != me.cyc) begin
            n_bad++;
            $display("FAIL mem_acc: got we=%0d addr=%h mask=%b din=%h cyc=%0d, required we=%0d addr=%h mask=%b din=%h cyc=%0d",
                     mem_write, mem_addr, mem_size, mem_din, cyc,
                     me.we, me.addr, me.mask, me.din, me.cyc);
          end
        end
      end else begin
        n_cmp++;
        if (mem_size !== 4'b0000) begin
          n_bad++;
          $display("FAIL mask_idle: got mem_size=%b, required 0000", mem_size);
        end
      end
      if (resp_valid) begin
        n_cmp++;
        n_resp++;
        if (rq.size() == 0) begin
          n_bad++;
          $display("FAIL resp_unexp: got rdata=%h err=%0d cyc=%0d, required no response",
                   resp_rdata, resp_err, cyc);
        end else begin
          re = rq.pop_front();
          if (resp_rdata !== re.rdata || resp_err !== re.err || cyc != re.cyc) begin
            n_bad++;
            $display("FAIL resp: got rdata=%h err=%0d cyc=%0d, required rdata=%h err=%0d cyc=%0d",
                     resp_rdata, resp_err, cyc, re.rdata, re.err, re.cyc);
          end else begin
            $display("resp %0d: rdata=%h err=%0d cyc=%0d", n_resp, resp_rdata, resp_err, cyc);
          end
        end
      end else begin
        n_cmp++;
        if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
          n_bad++;
          $display("FAIL resp_idle: got rdata=%h err=%0d, required 0/0", resp_rdata, resp_err);
        end
      end
    end
  end

  // Drive one request at a falling edge once ready. t is the cycle in which
  // the handshake happens.
  task automatic issue(input bit we, input bit [31:0] a, input bit [2:0] f3,
                       input bit [31:0] wd, output int t);
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: got req_ready=0 after 20 cycles, required 1");
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = a;
    req_funct3 = f3;
    req_wdata  = wd;
    t = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Issue a request and queue nacc expected RAM accesses plus one response
  // lat cycles after acceptance.
  task automatic op(input bit we, input bit [31:0] a, input bit [2:0] f3, input bit [31:0] wd,
                    input bit [31:0] exp_rd, input bit exp_err, input int lat, input int nacc,
                    input bit [9:0] a0, input bit [3:0] m0, input bit [31:0] d0,
                    input bit [9:0] a1, input bit [3:0] m1, input bit [31:0] d1);
    int t;
    issue(we, a, f3, wd, t);
    if (nacc >= 1) mq.push_back('{we, a0, m0, d0, t + 1});
    if (nacc >= 2) mq.push_back('{we, a1, m1, d1, t + 2});
    rq.push_back('{exp_rd, exp_err, t + lat});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", 32'(resp_err), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("rst_mem_size", 32'(mem_size), 32'h0);
    chk("rst_mem_din", mem_din, 32'h0);
    rst_n = 1'b1;

    // Word store/load
    op(1, 32'h010, 3'b010, 32'hDEADBEEF, 32'h0, 0, 2, 1, 10'h010, 4'b1111, 32'hDEADBEEF, 10'h0, 4'h0, 32'h0);
    op(0, 32'h010, 3'b010, 32'h0, 32'hDEADBEEF, 0, 2, 1, 10'h010, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0);
    // Byte store into lane 2 and byte/half loads (word becomes DEA5BEEF)
    op(1, 32'h012, 3'b000, 32'h000000A5, 32'h0, 0, 2, 1, 10'h010, 4'b0100, 32'h00A50000, 10'h0, 4'h0, 32'h0);
    op(0, 32'h012, 3'b000, 32'h0, 32'hFFFFFFA5, 0, 2, 1, 10'h010, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0);
    op(0, 32'h012, 3'b100, 32'h0, 32'h000000A5, 0, 2, 1, 10'h010, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0);
    op(0, 32'h012, 3'b001, 32'h0, 32'hFFFFDEA5, 0, 2, 1, 10'h010, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0);
    op(0, 32'h012, 3'b101, 32'h0, 32'h0000DEA5, 0, 2, 1, 10'h010, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0);
    op(0, 32'h011, 3'b001, 32'h0, 32'hFFFFA5BE, 0, 2, 1, 10'h010, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0);
    op(1, 32'h016, 3'b001, 32'h0000CAFE, 32'h0, 0, 2, 1, 10'h014, 4'b1100, 32'hCAFE0000, 10'h0, 4'h0, 32'h0);
    op(0, 32'h014, 3'b010, 32'h0, 32'hCAFE0000, 0, 2, 1, 10'h014, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0);
    // Within-word misaligned accesses
    op(1, 32'h020, 3'b010, 32'h89ABCDEF, 32'h0, 0, 2, 1, 10'h020, 4'b1111, 32'h89ABCDEF, 10'h0, 4'h0, 32'h0);
    op(0, 32'h021, 3'b001, 32'h0, 32'hFFFFABCD, 0, 2, 1, 10'h020, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0);
    op(0, 32'h023, 3'b000, 32'h0, 32'hFFFFFF89, 0, 2, 1, 10'h020, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0);
    op(0, 32'h023, 3'b100, 32'h0, 32'h00000089, 0, 2, 1, 10'h020, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0);
    // Illegal funct3: response one cycle later, no RAM access
    op(0, 32'h010, 3'b011, 32'h0, 32'h0, 1, 1, 0, 10'h0, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0);
    op(0, 32'h010, 3'b110, 32'h0, 32'h0, 1, 1, 0, 10'h0, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0);
    op(1, 32'h010, 3'b011, 32'h12345678, 32'h0, 1, 1, 0, 10'h0, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0);
    op(1, 32'h010, 3'b100, 32'h12345678, 32'h0, 1, 1, 0, 10'h0, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0);
    // Word-crossing accesses
`ifdef DMEM_LSU_MISALIGN_EN
    op(1, 32'h023, 3'b010, 32'h11223344, 32'h0, 0, 3, 2, 10'h020, 4'b1000, 32'h44000000, 10'h024, 4'b0111, 32'h00112233);
    op(0, 32'h023, 3'b010, 32'h0, 32'h11223344, 0, 3, 2, 10'h020, 4'h0, 32'h0, 10'h024, 4'h0, 32'h0);
    op(0, 32'h023, 3'b001, 32'h0, 32'h00003344, 0, 3, 2, 10'h020, 4'h0, 32'h0, 10'h024, 4'h0, 32'h0);
`else
    op(0, 32'h023, 3'b010, 32'h0, 32'h0, 1, 2, 0, 10'h0, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0);
    op(1, 32'h023, 3'b010, 32'h11223344, 32'h0, 1, 2, 0, 10'h0, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0);
    op(0, 32'h023, 3'b001, 32'h0, 32'h0, 1, 2, 0, 10'h0, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0);
    op(0, 32'h020, 3'b010, 32'h0, 32'h89ABCDEF, 0, 2, 1, 10'h020, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0);
`endif

    // A request held while the LSU is busy must not be taken
    issue(0, 32'h010, 3'b010, 32'h0, t);
    mq.push_back('{1'b0, 10'h010, 4'h0, 32'h0, t + 1});
    rq.push_back('{32'hDEA5BEEF, 1'b0, t + 2});
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h010;
    req_funct3 = 3'b010;
    req_wdata  = 32'h0BADF00D;
    @(posedge clk);
    @(posedge clk);
    #1 req_valid = 1'b0;

    // Reset in the middle of an access
`ifdef DMEM_LSU_MISALIGN_EN
    issue(0, 32'h023, 3'b010, 32'h0, t);
    mq.push_back('{1'b0, 10'h020, 4'h0, 32'h0, t + 1});
    @(posedge clk);
    #1 rst_n = 1'b0;
`else
    issue(0, 32'h010, 3'b010, 32'h0, t);
    rst_n = 1'b0;
`endif
    @(negedge clk);
    chk("midrst_ready", 32'(req_ready), 32'h1);
    chk("midrst_resp_valid", 32'(resp_valid), 32'h0);
    chk("midrst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Address wrap and ignored upper address bits
    op(1, 32'hFFFFF3FC, 3'b010, 32'hA1B2C3D4, 32'h0, 0, 2, 1, 10'h3FC, 4'b1111, 32'hA1B2C3D4, 10'h0, 4'h0, 32'h0);
    op(0, 32'h000003FC, 3'b010, 32'h0, 32'hA1B2C3D4, 0, 2, 1, 10'h3FC, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0);
    op(1, 32'h00000000, 3'b010, 32'h00000077, 32'h0, 0, 2, 1, 10'h000, 4'b1111, 32'h00000077, 10'h0, 4'h0, 32'h0);
`ifdef DMEM_LSU_MISALIGN_EN
    op(0, 32'h3FF, 3'b001, 32'h0, 32'h000077A1, 0, 3, 2, 10'h3FC, 4'h0, 32'h0, 10'h000, 4'h0, 32'h0);
    op(0, 32'h3FE, 3'b010, 32'h0, 32'h0077A1B2, 0, 3, 2, 10'h3FC, 4'h0, 32'h0, 10'h000, 4'h0, 32'h0);
    op(1, 32'h3FF, 3'b001, 32'h0000BEEF, 32'h0, 0, 3, 2, 10'h3FC, 4'b1000, 32'hEF000000, 10'h000, 4'b0001, 32'h000000BE);
    op(0, 32'h000, 3'b010, 32'h0, 32'h000000BE, 0, 2, 1, 10'h000, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0);
`else
    op(0, 32'h3FF, 3'b001, 32'h0, 32'h0, 1, 2, 0, 10'h0, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0);
    op(0, 32'h000, 3'b010, 32'h0, 32'h00000077, 0, 2, 1, 10'h000, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0);
`endif

    repeat (5) @(negedge clk);
    chk("mem_queue_drained", 32'(mq.size()), 32'h0);
    chk("resp_queue_drained", 32'(rq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
